// File: rtl/ram_scan_ctrl.sv
// rtl/ram_scan_ctrl.sv - periodic RAM scanner with write injection and display capture
module ram_scan_ctrl #(
  parameter int TICK_CYCLES = 50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_req,
  input  logic [4:0] wr_addr,
  input  logic [2:0] wr_data,
  input  logic [2:0] ram_q,
  output logic [4:0] ram_addr,
  output logic [2:0] ram_data,
  output logic       ram_wren,
  output logic [4:0] disp_addr,
  output logic [2:0] disp_data,
  output logic       disp_valid,
  output logic       wr_busy
);

  localparam int CW = $clog2(TICK_CYCLES);

  typedef enum logic [1:0] {IDLE, WRITE, READ, CAPTURE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;
  logic [4:0]    scan_addr_q, scan_addr_d;
  logic          pend_wr_q, pend_wr_d;
  logic          pend_tick_q, pend_tick_d;
  logic [4:0]    lat_addr_q, lat_addr_d;
  logic [2:0]    lat_data_q, lat_data_d;
  logic [4:0]    disp_addr_q, disp_addr_d;
  logic [2:0]    disp_data_q, disp_data_d;
  logic          disp_valid_q, disp_valid_d;

  // Free-running step counter; tick fires on its last count
  always_comb begin
    tick       = (tick_cnt_q == CW'(TICK_CYCLES - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + CW'(1);
  end

  // Next state, pending write/tick bookkeeping and display updates
  always_comb begin
    state_d      = state_q;
    scan_addr_d  = scan_addr_q;
    pend_wr_d    = pend_wr_q;
    pend_tick_d  = pend_tick_q;
    lat_addr_d   = lat_addr_q;
    lat_data_d   = lat_data_q;
    disp_addr_d  = disp_addr_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = disp_valid_q;

    case (state_q)
      IDLE: begin
        if (wr_req) begin
          lat_addr_d  = wr_addr;
          lat_data_d  = wr_data;
          pend_wr_d   = 1'b0;
          pend_tick_d = pend_tick_q | tick;
          state_d     = WRITE;
        end else if (pend_wr_q) begin
          pend_wr_d   = 1'b0;
          pend_tick_d = pend_tick_q | tick;
          state_d     = WRITE;
        end else if (tick || pend_tick_q) begin
          // When both a pending and a fresh tick exist, one is consumed and one stays pending
          pend_tick_d = pend_tick_q & tick;
          state_d     = READ;
        end
      end
      WRITE: begin
        // Keep the displayed word coherent with a write to the same address
        if (disp_valid_q && (lat_addr_q == disp_addr_q)) begin
          disp_data_d = lat_data_q;
        end
        state_d = IDLE;
      end
      READ: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        disp_data_d  = ram_q;
        disp_addr_d  = scan_addr_q;
        disp_valid_d = 1'b1;
        scan_addr_d  = scan_addr_q + 5'd1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Requests arriving while busy are parked; the latch is only read in WRITE,
    // so overwriting it on the WRITE exit edge is harmless
    if (state_q != IDLE) begin
      if (wr_req) begin
        lat_addr_d = wr_addr;
        lat_data_d = wr_data;
        pend_wr_d  = 1'b1;
      end
      if (tick) begin
        pend_tick_d = 1'b1;
      end
    end
  end

  // State register with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      tick_cnt_q   <= '0;
      scan_addr_q  <= '0;
      pend_wr_q    <= 1'b0;
      pend_tick_q  <= 1'b0;
      lat_addr_q   <= '0;
      lat_data_q   <= '0;
      disp_addr_q  <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      scan_addr_q  <= scan_addr_d;
      pend_wr_q    <= pend_wr_d;
      pend_tick_q  <= pend_tick_d;
      lat_addr_q   <= lat_addr_d;
      lat_data_q   <= lat_data_d;
      disp_addr_q  <= disp_addr_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
    end
  end

  // RAM port and status decode straight from state and registers
  always_comb begin
    ram_wren   = (state_q == WRITE);
    ram_addr   = (state_q == WRITE) ? lat_addr_q : scan_addr_q;
    ram_data   = (state_q == WRITE) ? lat_data_q : 3'd0;
    wr_busy    = (state_q != IDLE);
    disp_addr  = disp_addr_q;
    disp_data  = disp_data_q;
    disp_valid = disp_valid_q;
  end

endmodule
